// File: rtl/out_fm_tile_sched.sv
// Layer-job sequencer: for each output tile, walks the input-channel tiles through
// partial-sum load, convolution and store, pulsing the engine starts and consuming their dones.
module out_fm_tile_sched #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_in_tiles,
  input  logic [CW-1:0] num_out_tiles,
  output logic          busy,
  output logic          job_done,
  output logic          out_fm_ld_start,
  input  logic          out_fm_ld_done,
  output logic          conv_start,
  input  logic          conv_done,
  output logic          acc_init,
  output logic          out_fm_st_start,
  input  logic          out_fm_st_done,
  output logic          st_final,
  output logic [CW-1:0] in_tile_idx,
  output logic [CW-1:0] out_tile_idx
);

  typedef enum logic [3:0] {
    IDLE, LD_REQ, LD_WAIT, CONV_REQ, CONV_WAIT, ST_REQ, ST_WAIT, NEXT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] num_in_q, num_in_d;
  logic [CW-1:0] num_out_q, num_out_d;
  logic [CW-1:0] in_idx_d, out_idx_d;
  logic          last_in, last_out;

  logic busy_d, job_done_d, ld_start_d, conv_start_d, acc_init_d, st_start_d, st_final_d;

  assign last_in  = (in_tile_idx  == num_in_q  - CW'(1));
  assign last_out = (out_tile_idx == num_out_q - CW'(1));

  // Next state, next counters, and the output decode of that next state
  always_comb begin
    state_d   = state_q;
    num_in_d  = num_in_q;
    num_out_d = num_out_q;
    in_idx_d  = in_tile_idx;
    out_idx_d = out_tile_idx;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_in_d  = (num_in_tiles == '0) ? CW'(1) : num_in_tiles;
          num_out_d = num_out_tiles;
          in_idx_d  = '0;
          out_idx_d = '0;
          state_d   = (num_out_tiles == '0) ? DONE : CONV_REQ;
        end
      end
      LD_REQ:    state_d = LD_WAIT;
      LD_WAIT:   if (out_fm_ld_done) state_d = CONV_REQ;
      CONV_REQ:  state_d = CONV_WAIT;
      CONV_WAIT: if (conv_done) state_d = ST_REQ;
      ST_REQ:    state_d = ST_WAIT;
      ST_WAIT:   if (out_fm_st_done) state_d = NEXT;
      NEXT: begin
        if (last_in) begin
          in_idx_d = '0;
          if (last_out) begin
            state_d = DONE;
          end else begin
            out_idx_d = out_tile_idx + CW'(1);
            state_d   = CONV_REQ;
          end
        end else begin
          in_idx_d = in_tile_idx + CW'(1);
          state_d  = LD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    job_done_d   = (state_d == DONE);
    ld_start_d   = (state_d == LD_REQ);
    conv_start_d = (state_d == CONV_REQ);
    st_start_d   = (state_d == ST_REQ);
    acc_init_d   = ((state_d == CONV_REQ) || (state_d == CONV_WAIT)) && (in_idx_d == '0);
    st_final_d   = ((state_d == ST_REQ) || (state_d == ST_WAIT)) &&
                   (in_idx_d == num_in_d - CW'(1));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      num_in_q        <= '0;
      num_out_q       <= '0;
      in_tile_idx     <= '0;
      out_tile_idx    <= '0;
      busy            <= 1'b0;
      job_done        <= 1'b0;
      out_fm_ld_start <= 1'b0;
      conv_start      <= 1'b0;
      acc_init        <= 1'b0;
      out_fm_st_start <= 1'b0;
      st_final        <= 1'b0;
    end else begin
      state_q         <= state_d;
      num_in_q        <= num_in_d;
      num_out_q       <= num_out_d;
      in_tile_idx     <= in_idx_d;
      out_tile_idx    <= out_idx_d;
      busy            <= busy_d;
      job_done        <= job_done_d;
      out_fm_ld_start <= ld_start_d;
      conv_start      <= conv_start_d;
      acc_init        <= acc_init_d;
      out_fm_st_start <= st_start_d;
      st_final        <= st_final_d;
    end
  end

endmodule

// File: tb/tb_out_fm_tile_sched.sv
// Directed bench for out_fm_tile_sched: auto-responding engines, event logs, and
// hand-derived pulse timing, counts and index sequences.
module tb_out_fm_tile_sched;

  // Narrow counters keep the full-range output-tile job short.
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [CW-1:0] num_in_tiles, num_out_tiles;
  logic          busy, job_done, out_fm_ld_start, conv_start, acc_init;
  logic          out_fm_st_start, st_final;
  logic          out_fm_ld_done, conv_done, out_fm_st_done;
  logic [CW-1:0] in_tile_idx, out_tile_idx;

  logic ld_auto, conv_auto, st_auto;
  logic ld_inj, conv_inj, st_inj;
  assign out_fm_ld_done = ld_auto | ld_inj;
  assign conv_done      = conv_auto | conv_inj;
  assign out_fm_st_done = st_auto | st_inj;

  out_fm_tile_sched #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_in_tiles(num_in_tiles), .num_out_tiles(num_out_tiles),
    .busy(busy), .job_done(job_done),
    .out_fm_ld_start(out_fm_ld_start), .out_fm_ld_done(out_fm_ld_done),
    .conv_start(conv_start), .conv_done(conv_done), .acc_init(acc_init),
    .out_fm_st_start(out_fm_st_start), .out_fm_st_done(out_fm_st_done),
    .st_final(st_final), .in_tile_idx(in_tile_idx), .out_tile_idx(out_tile_idx)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int in_i; int out_i; int flag; } ev_t;
  ev_t conv_q[$];
  ev_t st_q[$];
  int  n_ld = 0, n_jd = 0, jd_cyc = -1, busy_rise = -1, busy_fall = -1;
  int  ld_dly = 3, conv_dly = 3, st_dly = 3;
  int  n_cmp = 0, n_err = 0;

  // Engine model and event monitor, evaluated on the falling edge
  initial begin
    int ld_cd, conv_cd, st_cd;
    logic busy_prev;
    ld_cd = 0; conv_cd = 0; st_cd = 0; busy_prev = 1'b0;
    ld_auto = 1'b0; conv_auto = 1'b0; st_auto = 1'b0;
    forever begin
      @(negedge clk);
      ld_auto = 1'b0; conv_auto = 1'b0; st_auto = 1'b0;
      if (ld_cd > 0)   begin ld_cd--;   if (ld_cd == 0)   ld_auto = 1'b1;   end
      if (conv_cd > 0) begin conv_cd--; if (conv_cd == 0) conv_auto = 1'b1; end
      if (st_cd > 0)   begin st_cd--;   if (st_cd == 0)   st_auto = 1'b1;   end
      if (out_fm_ld_start) begin n_ld++; ld_cd = ld_dly; end
      if (conv_start) begin
        conv_q.push_back('{cyc, int'(in_tile_idx), int'(out_tile_idx), int'(acc_init)});
        conv_cd = conv_dly;
      end
      if (out_fm_st_start) begin
        st_q.push_back('{cyc, int'(in_tile_idx), int'(out_tile_idx), int'(st_final)});
        st_cd = st_dly;
      end
      if (job_done) begin n_jd++; jd_cyc = cyc; end
      if (busy && !busy_prev) busy_rise = cyc;
      if (!busy && busy_prev) busy_fall = cyc - 1;
      busy_prev = busy;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic ev_t conv_at(input int i);
    ev_t e = '{-1, -1, -1, -1};
    if (i < conv_q.size()) e = conv_q[i];
    return e;
  endfunction

  function automatic ev_t st_at(input int i);
    ev_t e = '{-1, -1, -1, -1};
    if (i < st_q.size()) e = st_q[i];
    return e;
  endfunction

  function automatic int outs_vec();
    return int'({job_done, out_fm_ld_start, conv_start, acc_init, out_fm_st_start, st_final});
  endfunction

  task automatic pulse_start(input int ni, input int no, output int t);
    @(posedge clk); #1;
    num_in_tiles  = CW'(ni);
    num_out_tiles = CW'(no);
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_jd(input string tag, input int j0, input int budget);
    int k = 0;
    while (n_jd == j0 && k < budget) begin @(posedge clk); k++; end
    repeat (2) @(posedge clk);
    check({tag, "_jd_count"}, n_jd - j0, 1);
  endtask

  // Single-tile job: conv_done 4 cycles after conv_start, st_done 3 after st_start
  task automatic run_s1(input string tag, input int ni);
    int t, c0, s0, l0, j0;
    c0 = conv_q.size(); s0 = st_q.size(); l0 = n_ld; j0 = n_jd;
    conv_dly = 4; st_dly = 3; ld_dly = 3;
    pulse_start(ni, 1, t);
    wait_jd(tag, j0, 100);
    check({tag, "_conv_cyc"},  conv_at(c0).cyc, t + 1);
    check({tag, "_acc_init"},  conv_at(c0).flag, 1);
    check({tag, "_n_conv"},    conv_q.size() - c0, 1);
    check({tag, "_n_ld"},      n_ld - l0, 0);
    check({tag, "_st_cyc"},    st_at(s0).cyc, t + 6);
    check({tag, "_st_final"},  st_at(s0).flag, 1);
    check({tag, "_n_st"},      st_q.size() - s0, 1);
    check({tag, "_jd_cyc"},    jd_cyc, t + 11);
    check({tag, "_busy_rise"}, busy_rise, t + 1);
    check({tag, "_busy_fall"}, busy_fall, t + 11);
  endtask

  initial begin
    int t, c0, s0, l0, j0, viol;
    rst = 1'b1; start = 1'b0; num_in_tiles = '0; num_out_tiles = '0;
    ld_inj = 1'b0; conv_inj = 1'b0; st_inj = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_outs", outs_vec(), 0);
    check("rst_in_idx", int'(in_tile_idx), 0);
    check("rst_out_idx", int'(out_tile_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Scenario 1
    run_s1("s1", 1);

    // Scenario 2: 3 input tiles x 2 output tiles
    c0 = conv_q.size(); s0 = st_q.size(); l0 = n_ld; j0 = n_jd;
    ld_dly = 3; conv_dly = 3; st_dly = 3;
    pulse_start(3, 2, t);
    wait_jd("s2", j0, 300);
    check("s2_n_ld", n_ld - l0, 4);
    check("s2_n_conv", conv_q.size() - c0, 6);
    check("s2_n_st", st_q.size() - s0, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s2_conv%0d_in", i),  conv_at(c0 + i).in_i,  i % 3);
      check($sformatf("s2_conv%0d_out", i), conv_at(c0 + i).out_i, i / 3);
      check($sformatf("s2_conv%0d_acc", i), conv_at(c0 + i).flag,  (i % 3 == 0) ? 1 : 0);
      check($sformatf("s2_st%0d_final", i), st_at(s0 + i).flag,    (i % 3 == 2) ? 1 : 0);
    end

    // Scenario 3a: empty job
    c0 = conv_q.size(); s0 = st_q.size(); l0 = n_ld; j0 = n_jd;
    pulse_start(5, 0, t);
    wait_jd("s3a", j0, 20);
    check("s3a_jd_cyc", jd_cyc, t + 1);
    check("s3a_n_conv", conv_q.size() - c0, 0);
    check("s3a_n_st", st_q.size() - s0, 0);
    check("s3a_n_ld", n_ld - l0, 0);

    // Scenario 3b: num_in=0 behaves as one input tile
    run_s1("s3b", 0);

    // Scenario 4: stray dones and a second start mid-job
    c0 = conv_q.size(); s0 = st_q.size(); l0 = n_ld; j0 = n_jd;
    ld_dly = 3; conv_dly = 3; st_dly = 3;
    pulse_start(2, 1, t);
    while (cyc < t + 26) begin
      @(posedge clk); #1;
      st_inj = 1'b0; conv_inj = 1'b0; start = 1'b0;
      case (cyc - t)
        2:  st_inj = 1'b1;
        3:  begin start = 1'b1; num_in_tiles = CW'(9); num_out_tiles = CW'(3); end
        11: conv_inj = 1'b1;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    st_inj = 1'b0; conv_inj = 1'b0; start = 1'b0;
    wait_jd("s4", j0, 50);
    check("s4_st0_cyc", st_at(s0).cyc, t + 5);
    check("s4_conv1_cyc", conv_at(c0 + 1).cyc, t + 14);
    check("s4_conv1_in", conv_at(c0 + 1).in_i, 1);
    check("s4_conv1_acc", conv_at(c0 + 1).flag, 0);
    check("s4_st1_final", st_at(s0 + 1).flag, 1);
    check("s4_n_conv", conv_q.size() - c0, 2);
    check("s4_n_st", st_q.size() - s0, 2);
    check("s4_n_ld", n_ld - l0, 1);
    check("s4_jd_cyc", jd_cyc, t + 23);

    // Scenario 5: reset while waiting on a load
    c0 = conv_q.size(); l0 = n_ld; j0 = n_jd;
    ld_dly = 3; conv_dly = 3; st_dly = 3;
    pulse_start(2, 1, t);
    while (cyc < t + 12) begin
      @(posedge clk); #1;
      rst = (cyc - t == 11);
    end
    rst = 1'b0;
    @(negedge clk);
    check("s5_busy", int'(busy), 0);
    check("s5_outs", outs_vec(), 0);
    check("s5_in_idx", int'(in_tile_idx), 0);
    check("s5_out_idx", int'(out_tile_idx), 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("s5_busy_late", int'(busy), 0);
    check("s5_n_conv", conv_q.size() - c0, 1);
    check("s5_n_ld", n_ld - l0, 1);
    check("s5_n_jd", n_jd - j0, 0);
    run_s1("s5_rerun", 1);

    // Scenario 6: full-range output-tile count
    c0 = conv_q.size(); s0 = st_q.size(); j0 = n_jd;
    ld_dly = 1; conv_dly = 1; st_dly = 1;
    pulse_start(2, (1 << CW) - 1, t);
    wait_jd("s6", j0, 2000);
    check("s6_n_conv", conv_q.size() - c0, 2 * ((1 << CW) - 1));
    check("s6_last_out", conv_at(conv_q.size() - 1).out_i, (1 << CW) - 2);
    check("s6_last_in", conv_at(conv_q.size() - 1).in_i, 1);
    check("s6_last_final", st_at(st_q.size() - 1).flag, 1);
    viol = 0;
    for (int i = c0 + 1; i < conv_q.size(); i++)
      if (conv_q[i].out_i < conv_q[i - 1].out_i) viol++;
    check("s6_out_monotonic", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
